inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Fetch-stage front end that sits directly upstream of the decode stage (decode feeds the immediate generator with inst[31:7]).
- Generates sequential PC-driven requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers the returned words with their PCs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- On a redirect from a branch or jump, it flushes the FIFO, squashes in-flight responses and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, number of FIFO entries; also the maximum of (FIFO count + outstanding requests). Must be a power of 2, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- im_req_valid  output  1  request to instruction memory.
- im_req_ready  input  1  memory accepts the request this cycle.
- im_req_addr  output  32  word-aligned fetch address.
- im_rsp_valid  input  1  response word valid; exactly one response per accepted request, in order, ≥1 cycle after acceptance.
- im_rsp_data  input  32  instruction word.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch PC.
- id_valid  output  1  FIFO head valid to decode.
- id_ready  input  1  decode consumes the head.
- id_pc  output  32  PC of the head instruction.
- id_inst  output  32  head instruction word.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; FIFO count, outstanding and drop_cnt = 0.
  - Outputs: im_req_valid=0, id_valid=0, id_pc=0, id_inst=0, im_req_addr=RESET_PC.
  - Reset asserted mid-operation discards everything. Responses arriving afterwards for pre-reset requests are not tracked; memory must be quiesced by system reset.
- Request issue:
  - im_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH).
  - im_req_addr = pc.
  - On accept (valid && ready): pc <= pc+4 (mod 2^32) and outstanding increments.
  - While valid && !ready, the address is held stable. Only a redirect may withdraw the request.
- Response:
  - If drop_cnt>0: the word is discarded, drop_cnt and outstanding are decremented.
  - Otherwise the word is pushed with its PC and outstanding is decremented. The FIFO's tail PC counter tracks resp PC: set on redirect, +4 per push.
  - Credit rule guarantees no overflow; a push into a full FIFO is impossible. The bench asserts this.
- Decode side:
  - id_valid = count != 0; id_pc and id_inst are driven from the FIFO head (registered storage).
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop: count unchanged.
  - When empty, id_pc and id_inst read 0.
- Latency: request accepted at cycle n with response at n+L gives id_valid at n+L+1. Minimum redirect-to-first-id_valid is 3 cycles with L=1.
- Redirect (redirect_valid=1 at edge):
  - Priority over all else.
  - FIFO cleared; any pop that cycle is ignored.
  - pc and resp-PC counter <= {redirect_pc[31:2],2'b00}.
  - drop_cnt <= outstanding minus 1 if a response arrives the same cycle, else outstanding. outstanding tracks the same value.
  - No request is issued in a redirect cycle.
  - Back-to-back redirects: the last one wins, and drop accounting stays exact.
- Counters: outstanding and drop_cnt are sized $clog2(DEPTH)+1 bits; they never exceed DEPTH. FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, memory with L=1, id_ready=1 -> addresses 0,4,8,… and id_pc 0,4,8 in order, one per cycle after startup. id_inst equals the memory contents, e.g. 0x00500093 at 0x0.
- id_ready=0 for 20 cycles -> exactly DEPTH=4 requests are accepted, id_valid stays 1 with id_pc=0, and im_req_valid drops to 0. Releasing id_ready resumes in order with no loss or duplicates.
- im_req_ready low for 3 cycles while im_req_valid=1 -> im_req_addr holds 0x8 unchanged and pc advances only on acceptance.
- Memory with L=3 and 3 requests outstanding; redirect_pc=0x100 -> the 3 stale responses are discarded and the first id_pc is 0x100.
- Redirect in the same cycle as a response and an id pop; redirect_pc=0x203 -> FIFO empty next cycle, fetch restarts at 0x200, and drop_cnt equals the remaining in-flight count.
- Reset asserted while the FIFO is full -> id_valid=0 and im_req_valid=0 in the following cycle, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues sequential PC requests to instruction memory, buffers
// returned words with their PCs in a small FIFO and hands them to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic          req_fire;
  logic          rsp_ack;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;

  // Credit covers both buffered words and words still in flight, so a
  // response can never land in a full FIFO.
  assign credit_used      = {1'b0, count_q} + {1'b0, out_q};
  assign im_req_valid     = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign im_req_addr      = pc_q;
  assign req_fire         = im_req_valid && im_req_ready;
  assign rsp_ack          = im_rsp_valid && (out_q != '0);
  assign push             = !rst && !redirect_valid && rsp_ack && (drop_q == '0);
  assign pop              = !redirect_valid && id_valid && id_ready;
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  assign id_valid = (count_q != '0);
  assign id_pc    = id_valid ? pc_mem_q[head_q]   : '0;
  assign id_inst  = id_valid ? inst_mem_q[head_q] : '0;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response landing this
      // very cycle is already being discarded and so is not counted again.
      pc_d     = redirect_aligned;
      rsp_pc_d = redirect_aligned;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      out_d    = rsp_ack ? out_q - CW'(1) : out_q;
      drop_d   = out_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_ack && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        tail_d   = tail_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      out_d   = out_q + CW'(req_fire) - CW'(rsp_ack);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= rsp_pc_q;
      inst_mem_q[tail_q] <= im_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases push expected
// decode-side words, a negedge monitor pops and compares them.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imReqValid;
  logic        imReqReady;
  logic [31:0] imReqAddr;
  logic        imRspValid;
  logic [31:0] imRspData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        idValid;
  logic        idReady;
  logic [31:0] idPc;
  logic [31:0] idInst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  exp_t    expQ[$];
  memReq_t memQ[$];

  int compared    = 0;
  int mismatched  = 0;
  int popCount    = 0;
  int acceptCount = 0;
  int cycle       = 0;
  int memLatency  = 1;
  int base;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req_valid   (imReqValid),
    .im_req_ready   (imReqReady),
    .im_req_addr    (imReqAddr),
    .im_rsp_valid   (imRspValid),
    .im_rsp_data    (imRspData),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .id_valid       (idValid),
    .id_ready       (idReady),
    .id_pc          (idPc),
    .id_inst        (idInst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], 16'h0013} ^ 32'h0000_1000;
  endfunction

  // Instruction memory model: in-order responses, memLatency cycles after accept.
  always @(negedge clk) begin
    memReq_t r;
    cycle++;
    if (rst) memQ.delete();
    if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      imRspValid = 1'b1;
      imRspData  = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      imRspValid = 1'b0;
      imRspData  = 32'hDEAD_BEEF;
    end
    if (imReqValid && imReqReady) begin
      r.addr = imReqAddr;
      r.due  = cycle + memLatency;
      memQ.push_back(r);
      acceptCount++;
      compared++;
      if (memQ.size() > DEPTH) begin
        mismatched++;
        $display("[TB] FAIL creditOverflow inflight=%0d allowed=%0d", memQ.size(), DEPTH);
      end
    end
  end

  // Decode-side monitor: every accepted pop must match the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && !redirectValid && idValid && idReady) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpectedPop pc=%h inst=%h required=none", idPc, idInst);
      end else begin
        e = expQ.pop_front();
        if (idPc !== e.pc || idInst !== e.inst) begin
          mismatched++;
          $display("[TB] FAIL decodeWord pc=%h inst=%h required pc=%h inst=%h",
                   idPc, idInst, e.pc, e.inst);
        end
      end
      popCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s got=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = memWord(e.pc);
      expQ.push_back(e);
    end
  endtask

  task automatic waitPops(input int target);
    int budget;
    budget = 0;
    while (popCount < target && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (popCount < target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL popTimeout got=%0d required=%0d", popCount, target);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the redirect edge.
  task automatic applyStimulus(input logic [31:0] pc);
    redirectValid = 1'b1;
    redirectPc    = pc;
    @(posedge clk);
    #1 redirectValid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    imReqReady    = 1'b1;
    idReady       = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    imRspValid    = 1'b0;
    imRspData     = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReqValid", 32'(imReqValid), 32'h0);
    checkOutput("rstIdValid",  32'(idValid),    32'h0);
    checkOutput("rstIdPc",     idPc,            32'h0);
    checkOutput("rstIdInst",   idInst,          32'h0);
    checkOutput("rstReqAddr",  imReqAddr,       RESET_PC);

    // Streaming with L=1
    @(posedge clk);
    #1 rst = 1'b0;
    idReady = 1'b1;
    pushExpected(32'h0, 8);
    waitPops(8);
    #1 idReady = 1'b0;

    // Decode stalled: exactly DEPTH requests, then request line drops
    applyStimulus(32'h0);
    acceptCount = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("stallAccepts",  32'(acceptCount), 32'd4);
    checkOutput("stallIdValid",  32'(idValid),     32'h1);
    checkOutput("stallIdPc",     idPc,             32'h0);
    checkOutput("stallIdInst",   idInst,           32'h0050_0093);
    checkOutput("stallReqValid", 32'(imReqValid),  32'h0);
    base = popCount;
    pushExpected(32'h0, 8);
    @(posedge clk);
    #1 idReady = 1'b1;
    waitPops(base + 8);
    #1 idReady = 1'b0;

    // Memory backpressure holds the address
    base = popCount;
    pushExpected(32'h0, 6);
    idReady = 1'b1;
    applyStimulus(32'h0);
    repeat (2) @(posedge clk);
    #1 imReqReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("holdReqValid", 32'(imReqValid), 32'h1);
      checkOutput("holdReqAddr",  imReqAddr,       32'h8);
      @(posedge clk);
    end
    #1 imReqReady = 1'b1;
    @(negedge clk);
    checkOutput("releaseAddr", imReqAddr, 32'h8);
    @(negedge clk);
    checkOutput("advanceAddr", imReqAddr, 32'hC);
    waitPops(base + 6);
    #1 idReady = 1'b0;

    // L=3, three in flight, redirect to 0x100
    memLatency = 3;
    applyStimulus(32'h0);
    repeat (3) @(posedge clk);
    #1;
    base = popCount;
    pushExpected(32'h100, 8);
    idReady = 1'b1;
    applyStimulus(32'h100);
    waitPops(base + 8);
    #1 idReady = 1'b0;

    // Redirect coinciding with a response and a decode pop, unaligned target
    memLatency = 2;
    base = popCount;
    pushExpected(32'h0, 4);
    idReady = 1'b1;
    applyStimulus(32'h0);
    waitPops(base + 4);
    #1;
    base = popCount;
    pushExpected(32'h200, 6);
    redirectValid = 1'b1;
    redirectPc    = 32'h203;
    @(negedge clk);
    checkOutput("popInRedirect",   32'(idValid),    32'h1);
    checkOutput("noReqInRedirect", 32'(imReqValid), 32'h0);
    @(posedge clk);
    #1 redirectValid = 1'b0;
    @(negedge clk);
    checkOutput("flushIdValid",  32'(idValid),    32'h0);
    checkOutput("restartAddr",   imReqAddr,       32'h200);
    checkOutput("restartReqVal", 32'(imReqValid), 32'h1);
    waitPops(base + 6);
    #1 idReady = 1'b0;

    // Reset while the FIFO is full
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("fullIdValid",  32'(idValid),    32'h1);
    checkOutput("fullReqValid", 32'(imReqValid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstReqValid", 32'(imReqValid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstIdValid", 32'(idValid), 32'h0);
    checkOutput("postRstIdPc",    idPc,         32'h0);
    checkOutput("postRstAddr",    imReqAddr,    RESET_PC);
    base = popCount;
    pushExpected(RESET_PC, 4);
    @(posedge clk);
    #1 idReady = 1'b1;
    waitPops(base + 4);
    #1 idReady = 1'b0;

    checkOutput("leftoverExpected", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
